hot_page_mig_dispatcher: RTL and testbench

- Downstream consumer of the hot-page address handler.
- Captures one migration group of MIG_GRP_SIZE src/dst page-address pairs on new_addr_available.
- Issues one 4 KB page-copy request per valid pair to the page-copy engine, with a bounded number of requests outstanding.
- Tracks completions and increments mig_done_cnt once per finished group. That counter feeds back upstream as the trigger for the next address fetch.

---
 rtl/hot_page_mig_dispatcher.sv | 109 ++++++++++
 tb/tb_hot_page_mig_dispatcher.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hot_page_mig_dispatcher.sv
// hot_page_mig_dispatcher: captures one migration group of page pairs and issues
// one page-copy request per valid pair, with a bounded number in flight.
module hot_page_mig_dispatcher #(
    parameter int MIG_GRP_SIZE = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   axi4_mm_clk,
    input  logic                                   axi4_mm_rst,
    input  logic                                   new_addr_available,
    input  logic [MIG_GRP_SIZE/2-1:0][63:0]        src_addr,
    input  logic [MIG_GRP_SIZE/2-1:0][63:0]        src_addr1,
    input  logic [MIG_GRP_SIZE/2-1:0][63:0]        dst_addr,
    input  logic [MIG_GRP_SIZE/2-1:0][63:0]        dst_addr1,
    output logic                                   copy_req_valid,
    input  logic                                   copy_req_ready,
    output logic [63:0]                            copy_req_src,
    output logic [63:0]                            copy_req_dst,
    output logic [$clog2(MIG_GRP_SIZE)-1:0]        copy_req_id,
    input  logic                                   copy_done_valid,
    output logic [63:0]                            mig_done_cnt,
    output logic [63:0]                            pages_copied_cnt,
    output logic [31:0]                            grp_drop_cnt,
    output logic                                   done_underflow_err,
    output logic                                   busy
);
    localparam int PW = $clog2(MIG_GRP_SIZE);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [63:0]   src_buf [MIG_GRP_SIZE];
    logic [63:0]   dst_buf [MIG_GRP_SIZE];
    logic [PW-1:0] issue_ptr;
    logic [OW-1:0] outstanding;
    logic          ent_valid, last, accept, skip, start, finish;

    assign ent_valid = src_buf[issue_ptr] != '0 && dst_buf[issue_ptr] != '0;
    assign last      = issue_ptr == PW'(MIG_GRP_SIZE - 1);
    assign accept    = copy_req_valid && copy_req_ready;
    assign skip      = state == ISSUE && !ent_valid;
    assign start     = state == IDLE && new_addr_available;
    assign finish    = state == DRAIN && outstanding == '0;

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE  ? (new_addr_available ? ISSUE : IDLE)
                  : state == ISSUE ? ((accept || skip) && last ? DRAIN : ISSUE)
                  : (outstanding == '0 ? IDLE : DRAIN);
    end

    // Payload comes straight from the buffer at issue_ptr, which only moves on
    // accept or skip, so a raised request stays stable until taken.
    always_comb begin
        busy           = state != IDLE;
        copy_req_valid = state == ISSUE && ent_valid && outstanding < OW'(MAX_OUTSTANDING);
        copy_req_src   = src_buf[issue_ptr];
        copy_req_dst   = dst_buf[issue_ptr];
        copy_req_id    = issue_ptr;
    end

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            for (int i = 0; i < MIG_GRP_SIZE; i++) begin
                src_buf[i] <= '0;
                dst_buf[i] <= '0;
            end
            issue_ptr          <= '0;
            outstanding        <= '0;
            mig_done_cnt       <= '0;
            pages_copied_cnt   <= '0;
            grp_drop_cnt       <= '0;
            done_underflow_err <= 1'b0;
        end else begin
            if (start) begin
                for (int i = 0; i < MIG_GRP_SIZE / 2; i++) begin
                    src_buf[2*i]   <= src_addr[i];
                    src_buf[2*i+1] <= src_addr1[i];
                    dst_buf[2*i]   <= dst_addr[i];
                    dst_buf[2*i+1] <= dst_addr1[i];
                end
                issue_ptr <= '0;
            end else if (accept || skip) begin
                issue_ptr <= issue_ptr + PW'(1);
            end
            // A simultaneous accept and done cancel out.
            if (start)
                outstanding <= '0;
            else if (accept && !copy_done_valid)
                outstanding <= outstanding + OW'(1);
            else if (!accept && copy_done_valid && outstanding != '0)
                outstanding <= outstanding - OW'(1);
            if (!accept && copy_done_valid && outstanding == '0)
                done_underflow_err <= 1'b1;
            if (accept)
                pages_copied_cnt <= pages_copied_cnt + 64'd1;
            if (finish)
                mig_done_cnt <= mig_done_cnt + 64'd1;
            if (new_addr_available && state != IDLE && grp_drop_cnt != '1)
                grp_drop_cnt <= grp_drop_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_hot_page_mig_dispatcher.sv
// tb_hot_page_mig_dispatcher: scoreboard bench for the migration dispatcher.
module tb_hot_page_mig_dispatcher;
    logic              clk = 1'b0;
    logic              axi4_mm_rst = 1'b1;
    logic              new_addr_available = 1'b0;
    logic [7:0][63:0]  src_addr = '0, src_addr1 = '0, dst_addr = '0, dst_addr1 = '0;
    logic              copy_req_valid, copy_req_ready = 1'b0;
    logic [63:0]       copy_req_src, copy_req_dst;
    logic [3:0]        copy_req_id;
    logic              copy_done_valid = 1'b0;
    logic [63:0]       mig_done_cnt, pages_copied_cnt;
    logic [31:0]       grp_drop_cnt;
    logic              done_underflow_err, busy;

    typedef struct {logic [3:0] id; logic [63:0] s; logic [63:0] d;} exp_t;
    exp_t        sb[$];
    logic [63:0] gs [16];
    logic [63:0] gd [16];
    int          vectors = 0, miscompares = 0;
    int          m_out = 0, grp_acc = 0;
    logic        acc_seen = 0, auto_done = 0, manual_done = 0, ready_en = 0, rand_ready = 0;
    logic [2:0]  hist = '0;

    hot_page_mig_dispatcher dut (
        .axi4_mm_clk(clk), .axi4_mm_rst(axi4_mm_rst), .new_addr_available(new_addr_available),
        .src_addr(src_addr), .src_addr1(src_addr1), .dst_addr(dst_addr), .dst_addr1(dst_addr1),
        .copy_req_valid(copy_req_valid), .copy_req_ready(copy_req_ready),
        .copy_req_src(copy_req_src), .copy_req_dst(copy_req_dst), .copy_req_id(copy_req_id),
        .copy_done_valid(copy_done_valid), .mig_done_cnt(mig_done_cnt),
        .pages_copied_cnt(pages_copied_cnt), .grp_drop_cnt(grp_drop_cnt),
        .done_underflow_err(done_underflow_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Copy-engine model: done returns three cycles after each accept.
    initial forever begin
        @(posedge clk);
        #2;
        hist = {hist[1:0], acc_seen};
        acc_seen = 0;
        copy_done_valid = (auto_done && hist[2]) || manual_done;
        copy_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_en;
    end

    // Monitor: pops the scoreboard on each handshake and tracks outstanding.
    always @(negedge clk) begin
        if (axi4_mm_rst) m_out = 0;
        else begin
            if (copy_req_valid && copy_req_ready) begin
                vectors++;
                if (m_out >= 4) begin
                    miscompares++;
                    $display("FAIL accept_while_full: outstanding=%0d required<4", m_out);
                end
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req: id=%0d src=%h, no request expected", copy_req_id, copy_req_src);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (copy_req_id !== e.id || copy_req_src !== e.s || copy_req_dst !== e.d) begin
                        miscompares++;
                        $display("FAIL req_payload: got id=%0d src=%h dst=%h required id=%0d src=%h dst=%h",
                                 copy_req_id, copy_req_src, copy_req_dst, e.id, e.s, e.d);
                    end
                end
                grp_acc++;
                acc_seen = 1;
                if (!copy_done_valid) m_out++;
            end else if (copy_done_valid && m_out > 0) m_out--;
        end
    end

    task set_basic;
        for (int e = 0; e < 16; e++) begin
            gs[e] = 64'h1000 * (e + 1);
            gd[e] = 64'h8000_0000 + 64'h1000 * e;
        end
    endtask

    task drive_pulse(input logic push);
        @(posedge clk);
        #1;
        for (int e = 0; e < 16; e++) begin
            if (e % 2 == 0) begin src_addr[e/2] = gs[e]; dst_addr[e/2] = gd[e]; end
            else begin src_addr1[e/2] = gs[e]; dst_addr1[e/2] = gd[e]; end
            if (push && gs[e] != 0 && gd[e] != 0) sb.push_back('{4'(e), gs[e], gd[e]});
        end
        grp_acc = 0;
        new_addr_available = 1;
        @(posedge clk);
        #1;
        new_addr_available = 0;
        src_addr = '1; src_addr1 = '1; dst_addr = '1; dst_addr1 = '1;
    endtask

    task wait_idle(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 400);
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    // Returns dones by hand for whatever is outstanding, until stop accepts or idle.
    task run_manual(input int stop);
        int n;
        n = 0;
        while (n < 400 && busy && grp_acc < stop) begin
            @(posedge clk);
            #1;
            manual_done = m_out != 0;
            n++;
        end
        @(posedge clk);
        #1;
        manual_done = 0;
    endtask

    task check_sb_empty(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_leftover: %0d expected requests never issued, required 0", name, sb.size());
        end
    endtask

    task test_reset;
        repeat (3) @(posedge clk);
        #1;
        axi4_mm_rst = 0;
        @(negedge clk);
        vectors++;
        if (busy !== 0 || copy_req_valid !== 0 || done_underflow_err !== 0) begin
            miscompares++;
            $display("FAIL reset_flags: busy=%0b valid=%0b err=%0b required 0 0 0", busy, copy_req_valid, done_underflow_err);
        end
        vectors++;
        if (mig_done_cnt !== 0 || pages_copied_cnt !== 0 || grp_drop_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_counters: mig=%0d pages=%0d drop=%0d required 0", mig_done_cnt, pages_copied_cnt, grp_drop_cnt);
        end
    endtask

    task test_basic;
        int n;
        logic prev_busy;
        set_basic();
        ready_en = 1; auto_done = 1;
        drive_pulse(1);
        n = 0;
        prev_busy = busy;
        while (mig_done_cnt != 1 && n < 400) begin
            prev_busy = busy;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (mig_done_cnt !== 1 || busy !== 0 || prev_busy !== 1) begin
            miscompares++;
            $display("FAIL basic_done_edge: mig=%0d busy=%0b prev_busy=%0b required 1 0 1", mig_done_cnt, busy, prev_busy);
        end
        vectors++;
        if (pages_copied_cnt !== 16) begin
            miscompares++;
            $display("FAIL basic_pages: got %0d required 16", pages_copied_cnt);
        end
        check_sb_empty("basic");
    endtask

    task test_backpressure;
        set_basic();
        ready_en = 1; auto_done = 0;
        drive_pulse(1);
        repeat (12) @(negedge clk);
        vectors++;
        if (grp_acc !== 4 || copy_req_valid !== 0) begin
            miscompares++;
            $display("FAIL bp_stall: accepts=%0d valid=%0b required 4 0", grp_acc, copy_req_valid);
        end
        @(posedge clk); #1; manual_done = 1;
        @(posedge clk); #1; manual_done = 0;
        repeat (6) @(negedge clk);
        vectors++;
        if (grp_acc !== 5 || copy_req_valid !== 0) begin
            miscompares++;
            $display("FAIL bp_release: accepts=%0d valid=%0b required 5 0", grp_acc, copy_req_valid);
        end
        run_manual(99);
        wait_idle("bp");
        vectors++;
        if (mig_done_cnt !== 2) begin
            miscompares++;
            $display("FAIL bp_mig: got %0d required 2", mig_done_cnt);
        end
        check_sb_empty("bp");
    endtask

    task test_skip;
        set_basic();
        gs[3] = 0; gs[7] = 0; gs[15] = 0;
        rand_ready = 1; auto_done = 1;
        drive_pulse(1);
        wait_idle("skip");
        repeat (5) @(negedge clk);
        rand_ready = 0;
        vectors++;
        if (grp_acc !== 13 || mig_done_cnt !== 3 || pages_copied_cnt !== 45) begin
            miscompares++;
            $display("FAIL skip_counts: accepts=%0d mig=%0d pages=%0d required 13 3 45", grp_acc, mig_done_cnt, pages_copied_cnt);
        end
        check_sb_empty("skip");
    endtask

    task test_all_zero;
        int k;
        for (int e = 0; e < 16; e++) begin gs[e] = 0; gd[e] = 0; end
        drive_pulse(1);
        k = 1;
        @(posedge clk); #1;
        while (mig_done_cnt != 4 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        vectors++;
        if (k !== 17 || grp_acc !== 0 || busy !== 0) begin
            miscompares++;
            $display("FAIL zero_timing: done after %0d cycles accepts=%0d busy=%0b required 17 0 0", k, grp_acc, busy);
        end
    endtask

    task test_drop;
        set_basic();
        ready_en = 1; auto_done = 0;
        drive_pulse(1);
        run_manual(11);
        for (int e = 0; e < 16; e++) begin gs[e] = 64'h5000_0000 + e; gd[e] = 64'h6000_0000 + e; end
        begin
            int keep;
            keep = grp_acc;
            drive_pulse(0);
            grp_acc = grp_acc + keep;
        end
        @(negedge clk);
        vectors++;
        if (grp_drop_cnt !== 1 || busy !== 1) begin
            miscompares++;
            $display("FAIL drop_count: drop=%0d busy=%0b required 1 1", grp_drop_cnt, busy);
        end
        run_manual(99);
        wait_idle("drop");
        vectors++;
        if (mig_done_cnt !== 5 || pages_copied_cnt !== 61) begin
            miscompares++;
            $display("FAIL drop_counts: mig=%0d pages=%0d required 5 61", mig_done_cnt, pages_copied_cnt);
        end
        check_sb_empty("drop");
    endtask

    task test_underflow;
        repeat (4) @(negedge clk);
        vectors++;
        if (done_underflow_err !== 0) begin
            miscompares++;
            $display("FAIL uf_pre: err=%0b required 0", done_underflow_err);
        end
        @(posedge clk); #1; manual_done = 1;
        @(posedge clk); #1; manual_done = 0;
        @(negedge clk);
        vectors++;
        if (done_underflow_err !== 1) begin
            miscompares++;
            $display("FAIL uf_set: err=%0b required 1", done_underflow_err);
        end
        // Outstanding must still be 0: a fresh group issues exactly four.
        set_basic();
        drive_pulse(1);
        repeat (12) @(negedge clk);
        vectors++;
        if (grp_acc !== 4 || done_underflow_err !== 1) begin
            miscompares++;
            $display("FAIL uf_outstanding: accepts=%0d err=%0b required 4 1", grp_acc, done_underflow_err);
        end
        run_manual(99);
        wait_idle("uf");
        check_sb_empty("uf");
    endtask

    task test_reset_mid;
        int n;
        set_basic();
        ready_en = 1; auto_done = 0;
        drive_pulse(1);
        n = 0;
        while (grp_acc < 2 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #2;
        axi4_mm_rst = 1;
        #1;
        vectors++;
        if (copy_req_valid !== 0 || busy !== 0) begin
            miscompares++;
            $display("FAIL rstmid_async: valid=%0b busy=%0b required 0 0", copy_req_valid, busy);
        end
        vectors++;
        if (mig_done_cnt !== 0 || pages_copied_cnt !== 0 || grp_drop_cnt !== 0 || done_underflow_err !== 0) begin
            miscompares++;
            $display("FAIL rstmid_counters: mig=%0d pages=%0d drop=%0d err=%0b required 0", mig_done_cnt, pages_copied_cnt, grp_drop_cnt, done_underflow_err);
        end
        sb.delete();
        @(posedge clk); #1;
        axi4_mm_rst = 0;
        manual_done = 1;
        @(posedge clk); #1; manual_done = 0;
        @(negedge clk);
        vectors++;
        if (done_underflow_err !== 1) begin
            miscompares++;
            $display("FAIL rstmid_stale_done: err=%0b required 1", done_underflow_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_skip();
        test_all_zero();
        test_drop();
        test_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
